tx_fmt: RTL
===========

# tx_fmt

Result formatter directly upstream of the UART transmitter. Accepts a 16-bit signed calculator result and converts it to decimal ASCII with an iterative binary-to-BCD (double-dabble) engine. Streams the characters one byte at a time into the transmitter's `tx_data`/`uout_valid` inputs, pacing itself on the transmitter's `tx_valid` (high during STOP) output.

## Interface
- `CONV_CYCLES`, 16: double-dabble iterations, one per input magnitude bit. Fixed; not to be overridden.
- `clk`  in  1  system clock, 50 MHz
- `n_rst`  in  1  reset; one clock; reset is synchronous and active-low
- `res_data`  in  16  signed two's-complement result
- `res_valid`  in  1  result present; captured when `res_valid && res_ready` at a rising edge
- `res_ready`  out  1  high only in IDLE
- `tx_data`  out  8  ASCII byte to transmitter; registered
- `uout_valid`  out  1  one-cycle start pulse to transmitter; registered
- `tx_valid`  in  1  transmitter STOP indicator; a high-then-low sequence marks frame completion

## Operation
- Reset values while `n_rst`=0 at an edge: state IDLE, `tx_data`=8'h00, `uout_valid`=0, `res_ready`=1 (combinational from state). Internal BCD, shift and index registers cleared.
- States: IDLE, CONV, LOAD, SEND, WAIT_HI, WAIT_LO.
- IDLE: on `res_valid`, latch sign = `res_data[15]` and magnitude = |`res_data`| as 16-bit unsigned (-32768 -> 16'h8000). Clear the 20-bit BCD register, then go to CONV.
- CONV: 16 cycles. Each cycle adds 3 to every BCD nibble >= 5, then shifts {bcd, mag} left by one. After the 16th cycle go to LOAD.
- Character list, in order:
  - '-' (8'h2D), only if sign=1.
  - Decimal digits, most significant first, 8'h30+nibble. Leading zeros suppressed; zeros after the first nonzero digit are kept. A value of 0 emits a single '0'.
  - Terminator per Configuration.
  - Maximum length 8 bytes.
- LOAD: register the next character into `tx_data`, then go to SEND.
- SEND: `uout_valid`=1 for this cycle only, then go to WAIT_HI.
- WAIT_HI: stay until `tx_valid`=1, then go to WAIT_LO.
- WAIT_LO: stay until `tx_valid`=0. Then go to LOAD if characters remain, otherwise IDLE.
- `tx_data` holds constant from LOAD through the end of WAIT_LO. The transmitter samples it during its START state, so it must not change mid-frame.
- `res_valid` while not in IDLE is ignored. There is no queue; the upstream block holds `res_valid` until it sees `res_ready`.
- There is no timeout in WAIT_HI/WAIT_LO. A stalled transmitter stalls this block.
- Reset mid-operation: the block aborts on the next edge and returns to reset values. Any transmitter frame already in flight completes on its own.

## Timing
- Capture edge = cycle 0. CONV occupies cycles 1–16, LOAD is cycle 17, first `uout_valid` pulse is cycle 18.
- Subsequent bytes:
  - LOAD is the cycle after WAIT_LO observes `tx_valid`=0.
  - `uout_valid` follows one cycle later.
  - Inter-byte gap = 2 cycles after frame completion, plus the transmitter's own latency.
- `res_ready` returns high the cycle after the final WAIT_LO exit. The earliest next capture is that same edge.
- `uout_valid` is never high on two consecutive cycles. Exactly one pulse per character.

## Configuration
- `TX_FMT_CRLF_EN` defined: append 8'h0D then 8'h0A after the digits. Maximum length 8.
- Undefined: no terminator. The list ends at the last digit; maximum length 6.
- The macro affects only the character list and byte counter width. CONV timing is unchanged.

## Test plan
- `res_data`=16'd123, macro defined, transmitter model asserts `tx_valid` 434 cycles after each pulse -> bytes 8'h31, 8'h32, 8'h33, 8'h0D, 8'h0A. First pulse at cycle 18; `res_ready`=1 after the fifth frame.
- `res_data`=16'h8000 -> 8'h2D, 8'h33, 8'h32, 8'h37, 8'h36, 8'h38, 8'h0D, 8'h0A. 16'd10000 -> 8'h31, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A (inner zeros kept).
- `res_data`=0 -> 8'h30, 8'h0D, 8'h0A. `res_data`=16'hFFFF -> 8'h2D, 8'h31, 8'h0D, 8'h0A.
- Second `res_valid` with 16'd7 asserted during WAIT_HI of byte 2 -> ignored. The first string completes unchanged; 16'd7 is captured only after `res_ready` returns high.
- `n_rst`=0 during WAIT_LO of byte 3 -> next edge gives `uout_valid`=0, `tx_data`=8'h00, `res_ready`=1. No further pulses until a new capture.
- Macro undefined, `res_data`=16'd123 -> exactly 3 pulses (8'h31, 8'h32, 8'h33), then IDLE.

Source files
------------

// File: rtl/tx_fmt.sv
// ---------------------------------------------------------------------------
// tx_fmt -- signed result to decimal ASCII formatter feeding a UART transmitter
//
// A 16-bit two's-complement result is captured in IDLE, its magnitude is
// converted to five BCD digits with an iterative double-dabble engine (one
// input bit per cycle), and the resulting character string ('-' if negative,
// digits with leading zeros suppressed, optional CR/LF) is handed to the
// transmitter one byte at a time.  Each byte is presented on tx_data, started
// with a one-cycle uout_valid pulse, and the next byte waits until the
// transmitter's tx_valid has gone high and then low again (frame complete).
//
// Optional feature macro: TX_FMT_CRLF_EN
//   defined   : append 8'h0D, 8'h0A after the digits (up to 8 bytes)
//   undefined : digits only (up to 6 bytes)
//
// Ports
//   clk         in   1   system clock
//   n_rst       in   1   synchronous active-low reset
//   res_data    in  16   signed result to format
//   res_valid   in   1   result present; captured when res_valid && res_ready
//   res_ready   out  1   high only while idle
//   tx_data     out  8   registered ASCII byte to the transmitter
//   uout_valid  out  1   registered one-cycle start pulse to the transmitter
//   tx_valid    in   1   transmitter STOP indicator (high then low = done)
// ---------------------------------------------------------------------------
module tx_fmt #(
  parameter int CONV_CYCLES = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [15:0] res_data,
  input  logic        res_valid,
  output logic        res_ready,
  output logic [7:0]  tx_data,
  output logic        uout_valid,
  input  logic        tx_valid
);

  localparam int DATA_W = 16;
  localparam int BCD_W  = 20;
  localparam int ITER_W = $clog2(CONV_CYCLES);

`ifdef TX_FMT_CRLF_EN
  localparam int MAX_CHARS = 8;
  localparam int IDX_W     = 4;
`else
  localparam int MAX_CHARS = 6;
  localparam int IDX_W     = 3;
`endif

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    LOAD,
    SEND,
    WAIT_HI,
    WAIT_LO
  } state_t;

  state_t                    state, state_n;
  logic                      sign;
  logic        [DATA_W-1:0]  mag;
  logic        [BCD_W-1:0]   bcd;
  logic        [ITER_W-1:0]  iter;
  logic        [IDX_W-1:0]   idx;
  logic signed [DATA_W-1:0]  res_s;

  logic        [7:0]         chars [MAX_CHARS];
  logic        [IDX_W-1:0]   n_chars;
  logic        [2:0]         wp;
  logic        [3:0]         digit;
  logic                      seen_nz;
  logic                      more;

  assign res_s     = res_data;
  assign res_ready = (state == IDLE);
  assign more      = (idx < n_chars);

  // Absolute value as unsigned; -32768 maps onto 16'h8000 naturally.
  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = v[DATA_W-1] ? (~v + 1'b1) : v;
    return r;
  endfunction

  // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int k = 0; k < BCD_W / 4; k++) begin
      if (r[k*4 +: 4] >= 4'd5) r[k*4 +: 4] = r[k*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Character list derived from the finished BCD value.  sign and bcd stay
  // frozen while the bytes are sent, so this table is stable for the whole
  // string and only idx walks through it.
  always_comb begin
    for (int i = 0; i < MAX_CHARS; i++) chars[i] = 8'h00;
    n_chars = '0;
    wp      = '0;
    digit   = '0;
    seen_nz = 1'b0;
    if (sign) begin
      chars[wp] = 8'h2D;
      wp        = wp + 1'b1;
      n_chars   = n_chars + 1'b1;
    end
    for (int d = BCD_W / 4 - 1; d >= 0; d--) begin
      digit = bcd[d*4 +: 4];
      // The units digit is always emitted so that zero prints as "0".
      if (digit != 4'd0 || seen_nz || d == 0) begin
        chars[wp] = {4'h3, digit};
        wp        = wp + 1'b1;
        n_chars   = n_chars + 1'b1;
        seen_nz   = 1'b1;
      end
    end
`ifdef TX_FMT_CRLF_EN
    chars[wp] = 8'h0D;
    wp        = wp + 1'b1;
    chars[wp] = 8'h0A;
    n_chars   = n_chars + 2'd2;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (res_valid) state_n = CONV;
      CONV:    if (iter == ITER_W'(CONV_CYCLES - 1)) state_n = LOAD;
      LOAD:    state_n = SEND;
      SEND:    state_n = WAIT_HI;
      WAIT_HI: if (tx_valid) state_n = WAIT_LO;
      WAIT_LO: if (!tx_valid) state_n = more ? LOAD : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Conversion datapath and registered transmitter outputs
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sign       <= 1'b0;
      mag        <= '0;
      bcd        <= '0;
      iter       <= '0;
      idx        <= '0;
      tx_data    <= 8'h00;
      uout_valid <= 1'b0;
    end else begin
      // The pulse is registered off LOAD so it is high exactly in SEND.
      uout_valid <= (state == LOAD);
      case (state)
        IDLE: begin
          if (res_valid) begin
            sign <= res_s[DATA_W-1];
            mag  <= magnitude(res_s);
            bcd  <= '0;
            iter <= '0;
            idx  <= '0;
          end
        end
        CONV: begin
          {bcd, mag} <= {add3(bcd), mag} << 1;
          iter       <= iter + 1'b1;
        end
        LOAD: begin
          tx_data <= chars[idx[2:0]];
          idx     <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
